// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one iteration per clock, signed 2*WIDTH-bit product with done pulse.
// Optional macro BOOTH_ZERO_BYPASS_EN: a zero operand skips the iterations and finishes on the next edge.
module booth_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic signed [WIDTH-1:0]     multiplicand,
    input  logic signed [WIDTH-1:0]     multiplier,
    output logic                        busy,
    output logic                        done,
    output logic signed [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH:0]         r_a;
    logic [WIDTH:0]         r_m;
    logic [WIDTH-1:0]       r_q;
    logic                   r_qm1;
    logic [CW-1:0]          r_cnt;
    logic [2*WIDTH-1:0]     r_product;

    logic                   w_add;
    logic                   w_sub;
    logic [WIDTH:0]         w_b;
    logic [WIDTH:0]         w_c;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_a_nxt;
    logic [WIDTH-1:0]       w_q_nxt;
    logic                   w_last;
    logic                   w_zero;

    assign w_add  = r_q[0] ^ r_qm1;
    assign w_sub  = r_q[0] & ~r_qm1;
    assign w_last = (r_cnt == CW'(1));

`ifdef BOOTH_ZERO_BYPASS_EN
    assign w_zero = (multiplicand == '0) || (multiplier == '0);
`else
    assign w_zero = 1'b0;
`endif

    // Subtraction reuses the adder: invert M through xor and inject the +1 as carry-in.
    assign w_b    = w_add ? (r_m ^ {(WIDTH+1){w_sub}}) : '0;
    assign w_c[0] = w_add & w_sub;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        logic w_p;
        assign w_p      = r_a[i] ^ w_b[i];
        assign w_sum[i] = w_p ^ w_c[i];
        if (i < WIDTH) begin : g_carry
            assign w_c[i+1] = (r_a[i] & w_b[i]) | (w_c[i] & w_p);
        end
    end

    assign w_a_nxt = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign w_q_nxt = {w_sum[0], r_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = w_zero ? S_DONE : S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_m   <= {multiplicand[WIDTH-1], multiplicand};
                        r_q   <= multiplier;
                        r_a   <= '0;
                        r_qm1 <= 1'b0;
                        r_cnt <= CW'(WIDTH);
                        if (w_zero) begin
                            r_product <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_a   <= w_a_nxt;
                    r_q   <= w_q_nxt;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_product <= {w_a_nxt[WIDTH-1:0], w_q_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed self-checking bench for booth_seq_mult at WIDTH=8.
// Outputs are sampled on the falling edge; the design works on the rising edge.
module tb_booth_seq_mult;

    localparam int WIDTH = 8;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    int n_checks = 0;
    int n_fail   = 0;

    booth_seq_mult #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called on a falling edge; start is sampled by the next rising edge.
    task automatic pulse_start(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(negedge clk);
        start        = 1'b0;
        multiplicand = 8'hA5;
        multiplier   = 8'h5A;
    endtask

    // Counts cycles after the accepting edge until done; optionally pokes start mid-run.
    task automatic wait_done(input int inject_at, output logic [2*WIDTH-1:0] prod,
                             output int busy_cnt, output int done_at);
        busy_cnt = 0;
        done_at  = 0;
        prod     = '0;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_at = k;
                prod    = product;
                break;
            end
            if (k == inject_at) begin
                start        = 1'b1;
                multiplicand = 8'd9;
                multiplier   = 8'd9;
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        start        = 1'b1;
        multiplicand = 8'd7;
        multiplier   = 8'd3;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (product !== 16'h0000) begin n_fail++; $display("FAIL reset_product: got %h expected 0000", product); end
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: got busy/done %b expected 00", {busy, done}); end
    endtask

    task automatic test_basic();
        logic [2*WIDTH-1:0] p;
        int bc, da;
        logic stable;
        pulse_start(8'd7, 8'd3);
        wait_done(0, p, bc, da);
        n_checks++;
        if (bc != 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
        n_checks++;
        if (da != 9) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 9", da); end
        n_checks++;
        if (p !== 16'h0015) begin n_fail++; $display("FAIL basic_product: got %h expected 0015", p); end
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (product !== 16'h0015 || done !== 1'b0 || busy !== 1'b0) stable = 1'b0;
        end
        n_checks++;
        if (stable !== 1'b1) begin n_fail++; $display("FAIL basic_hold: got product %h done %b expected 0015 0", product, done); end
    endtask

    task automatic test_signed();
        logic [WIDTH-1:0]   vm [4] = '{8'h80, 8'h80, 8'hFB, 8'h7F};
        logic [WIDTH-1:0]   vq [4] = '{8'h80, 8'h7F, 8'h06, 8'h7F};
        logic [2*WIDTH-1:0] ve [4] = '{16'h4000, 16'hC080, 16'hFFE2, 16'h3F01};
        logic [2*WIDTH-1:0] p;
        int bc, da;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pulse_start(vm[i], vq[i]);
            wait_done(0, p, bc, da);
            n_checks++;
            if (p !== ve[i] || da != 9) begin
                n_fail++;
                $display("FAIL signed_%0d: got %h at cycle %0d expected %h at cycle 9", i, p, da, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2*WIDTH-1:0] p;
        int bc, da;
        @(negedge clk);
        pulse_start(8'd7, 8'd3);
        wait_done(0, p, bc, da);
        n_checks++;
        if (p !== 16'h0015) begin n_fail++; $display("FAIL b2b_first: got %h expected 0015", p); end
        pulse_start(8'd2, 8'hFF);
        wait_done(4, p, bc, da);
        n_checks++;
        if (da != 9) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 9", da); end
        n_checks++;
        if (p !== 16'hFFFE) begin n_fail++; $display("FAIL b2b_product: got %h expected fffe", p); end
        n_checks++;
        if (bc != 8) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected 8", bc); end
        @(negedge clk);
        n_checks++;
        if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL b2b_after: got busy/done %b expected 00", {busy, done}); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse_start(8'd10, 8'd10);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++;
        if (product !== 16'h0000) begin n_fail++; $display("FAIL midrst_product: got %h expected 0000", product); end
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got activity %b expected 0", seen); end
    endtask

    task automatic test_zero();
        logic [2*WIDTH-1:0] p;
        int bc, da;
        pulse_start(8'd0, 8'hB3);
        wait_done(0, p, bc, da);
        n_checks++;
        if (p !== 16'h0000) begin n_fail++; $display("FAIL zero_product: got %h expected 0000", p); end
`ifdef BOOTH_ZERO_BYPASS_EN
        n_checks++;
        if (da != 1 || bc != 0) begin n_fail++; $display("FAIL zero_timing: got done %0d busy %0d expected 1 0", da, bc); end
`else
        n_checks++;
        if (da != 9 || bc != 8) begin n_fail++; $display("FAIL zero_timing: got done %0d busy %0d expected 9 8", da, bc); end
`endif
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        test_reset();
        test_basic();
        test_signed();
        test_back_to_back();
        test_reset_mid();
        test_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
